// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI byte slave / register file and the frame sequencer.
// SPI_FRAME_CHK_EN adds the chk_err pulse used by 3-byte checked write frames.
`timescale 1ns/1ps
interface spi_reg_ctrl_if;
  logic       data_ok;
  logic [7:0] spi_rx_reg;
  logic [7:0] spi_tx_reg;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       addr_err;
  logic       tmo_err;
`ifdef SPI_FRAME_CHK_EN
  logic       chk_err;

  modport slave (
    input  data_ok, spi_rx_reg, reg_rdata,
    output spi_tx_reg, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
           busy, addr_err, tmo_err, chk_err
  );
  modport master (
    output data_ok, spi_rx_reg, reg_rdata,
    input  spi_tx_reg, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
           busy, addr_err, tmo_err, chk_err
  );
`else
  modport slave (
    input  data_ok, spi_rx_reg, reg_rdata,
    output spi_tx_reg, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
           busy, addr_err, tmo_err
  );
  modport master (
    output data_ok, spi_rx_reg, reg_rdata,
    input  spi_tx_reg, reg_addr, reg_wdata, reg_wr_en, reg_rd_en,
           busy, addr_err, tmo_err
  );
`endif
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI frame sequencer: turns received bytes into {cmd, data} register transactions.
// Define SPI_FRAME_CHK_EN for 3-byte write frames carrying a check byte.
`timescale 1ns/1ps
module spi_reg_ctrl #(
  parameter logic [6:0]  ADDR_MAX    = 7'd31,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [7:0]  ID_BYTE     = 8'h5A
) (
  input  logic          clk,
  input  logic          rst,
  spi_reg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    RD_LOAD = 3'd2,
    RD_DATA = 3'd3,
    DISCARD = 3'd4
`ifdef SPI_FRAME_CHK_EN
    ,WR_CHK = 3'd5
`endif
  } state_t;

  state_t      state_r;
  logic        data_ok_d_r;
  logic [15:0] tmo_cnt_r;
  logic [7:0]  spi_tx_r;
  logic [6:0]  reg_addr_r;
  logic [7:0]  reg_wdata_r;
  logic        wr_en_r;
  logic        rd_en_r;
  logic        busy_r;
  logic        addr_err_r;
  logic        tmo_err_r;
  logic        byte_evt_s;
  logic        tmo_hit_s;

`ifdef SPI_FRAME_CHK_EN
  logic        chk_err_r;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
    return cmd ^ data ^ 8'hA5;
  endfunction

  assign bus.chk_err = chk_err_r;
`endif

  assign byte_evt_s = bus.data_ok & ~data_ok_d_r;
  // The timeout fires on the edge where the counter would reach TIMEOUT_CYC; a byte in that cycle wins.
  assign tmo_hit_s  = (state_r != IDLE) && !byte_evt_s && (tmo_cnt_r >= (TIMEOUT_CYC - 16'd1));

  assign bus.spi_tx_reg = spi_tx_r;
  assign bus.reg_addr   = reg_addr_r;
  assign bus.reg_wdata  = reg_wdata_r;
  assign bus.reg_wr_en  = wr_en_r;
  assign bus.reg_rd_en  = rd_en_r;
  assign bus.busy       = busy_r;
  assign bus.addr_err   = addr_err_r;
  assign bus.tmo_err    = tmo_err_r;

  // Frame state machine with registered strobes, status and transmit byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      data_ok_d_r <= 1'b0;
      tmo_cnt_r   <= 16'd0;
      spi_tx_r    <= ID_BYTE;
      reg_addr_r  <= 7'd0;
      reg_wdata_r <= 8'd0;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      addr_err_r  <= 1'b0;
      tmo_err_r   <= 1'b0;
`ifdef SPI_FRAME_CHK_EN
      chk_err_r   <= 1'b0;
`endif
    end else begin
      data_ok_d_r <= bus.data_ok;
      wr_en_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      addr_err_r  <= 1'b0;
      tmo_err_r   <= 1'b0;
`ifdef SPI_FRAME_CHK_EN
      chk_err_r   <= 1'b0;
`endif
      if ((state_r == IDLE) || byte_evt_s) begin
        tmo_cnt_r <= 16'd0;
      end else if (tmo_cnt_r != 16'hFFFF) begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end

      if (tmo_hit_s) begin
        state_r   <= IDLE;
        busy_r    <= 1'b0;
        spi_tx_r  <= ID_BYTE;
        tmo_err_r <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (byte_evt_s) begin
              reg_addr_r <= bus.spi_rx_reg[6:0];
              busy_r     <= 1'b1;
              if (bus.spi_rx_reg[6:0] > ADDR_MAX) begin
                addr_err_r <= 1'b1;
                state_r    <= DISCARD;
              end else if (bus.spi_rx_reg[7]) begin
                rd_en_r <= 1'b1;
                state_r <= RD_LOAD;
              end else begin
                state_r <= WR_DATA;
              end
            end
          end
          RD_LOAD: begin
            spi_tx_r <= bus.reg_rdata;
            state_r  <= RD_DATA;
          end
          RD_DATA: begin
            if (byte_evt_s) begin
              spi_tx_r <= ID_BYTE;
              busy_r   <= 1'b0;
              state_r  <= IDLE;
            end
          end
          WR_DATA: begin
            if (byte_evt_s) begin
              reg_wdata_r <= bus.spi_rx_reg;
`ifdef SPI_FRAME_CHK_EN
              state_r     <= WR_CHK;
`else
              wr_en_r     <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
`endif
            end
          end
`ifdef SPI_FRAME_CHK_EN
          WR_CHK: begin
            if (byte_evt_s) begin
              if (bus.spi_rx_reg == frame_chk({1'b0, reg_addr_r}, reg_wdata_r)) begin
                wr_en_r <= 1'b1;
              end else begin
                chk_err_r <= 1'b1;
              end
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
`endif
          DISCARD: begin
            if (byte_evt_s) begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
          default: begin
            spi_tx_r <= ID_BYTE;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
